// File: rtl/d_mem.sv
// Data memory stage for the single-cycle MIPS datapath: combinational loads,
// edge-committed byte-lane stores, alignment/range fault detection and access counters.
module d_mem #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      addr,
    input  logic [31:0]      write_data,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [1:0]       size,
    input  logic             load_unsigned,
    output logic [31:0]      read_data,
    output logic             fault,
    output logic             fault_sticky,
    output logic [CNT_W-1:0] load_count,
    output logic [CNT_W-1:0] store_count
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic [CNT_W-1:0] load_count_q, load_count_d;
    logic [CNT_W-1:0] store_count_q, store_count_d;
    logic             fault_sticky_q, fault_sticky_d;

    logic [AW-1:0]    idx_s;
    logic [1:0]       lane_s;
    logic             range_fault_s;
    logic             misalign_s;
    logic             fault_s;
    logic             load_ok_s;
    logic             store_ok_s;
    logic [31:0]      rd_word_s;
    logic [31:0]      shifted_s;
    logic [15:0]      half_s;
    logic [31:0]      read_data_s;
    logic [31:0]      wr_mask_s;
    logic [31:0]      wr_data_s;

    assign idx_s         = addr[AW+1:2];
    assign lane_s        = addr[1:0];
    assign range_fault_s = |addr[31:AW+2];
    assign fault_s       = (mem_read | mem_write) & (range_fault_s | misalign_s);
    assign load_ok_s     = mem_read & ~fault_s;
    assign store_ok_s    = mem_write & ~fault_s;
    assign rd_word_s     = mem_q[idx_s];
    assign shifted_s     = rd_word_s >> {lane_s, 3'b000};
    assign half_s        = addr[1] ? rd_word_s[31:16] : rd_word_s[15:0];

    // Alignment rules per access size; the reserved size always faults
    always_comb begin
        misalign_s = 1'b0;
        case (size)
            2'b00:   misalign_s = 1'b0;
            2'b01:   misalign_s = addr[0];
            2'b10:   misalign_s = |addr[1:0];
            default: misalign_s = 1'b1;
        endcase
    end

    // Load path: lane select and sign/zero extension from pre-write contents
    always_comb begin
        read_data_s = 32'd0;
        if (load_ok_s) begin
            case (size)
                2'b00:   read_data_s = {{24{~load_unsigned & shifted_s[7]}}, shifted_s[7:0]};
                2'b01:   read_data_s = {{16{~load_unsigned & half_s[15]}}, half_s};
                2'b10:   read_data_s = rd_word_s;
                default: read_data_s = 32'd0;
            endcase
        end else begin
            read_data_s = 32'd0;
        end
    end

    // Store lane mask and lane-replicated data
    always_comb begin
        wr_mask_s = 32'd0;
        wr_data_s = write_data;
        case (size)
            2'b00: begin
                wr_mask_s = 32'h0000_00FF << {lane_s, 3'b000};
                wr_data_s = {4{write_data[7:0]}};
            end
            2'b01: begin
                wr_mask_s = addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                wr_data_s = {2{write_data[15:0]}};
            end
            2'b10: begin
                wr_mask_s = 32'hFFFF_FFFF;
                wr_data_s = write_data;
            end
            default: begin
                wr_mask_s = 32'd0;
                wr_data_s = write_data;
            end
        endcase
    end

    // Next state: array merge, counters and sticky fault
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        load_count_d   = load_count_q + {{(CNT_W-1){1'b0}}, load_ok_s};
        store_count_d  = store_count_q + {{(CNT_W-1){1'b0}}, store_ok_s};
        fault_sticky_d = fault_sticky_q | fault_s;
        if (store_ok_s) begin
            mem_d[idx_s] = (rd_word_s & ~wr_mask_s) | (wr_data_s & wr_mask_s);
        end else begin
            mem_d[idx_s] = rd_word_s;
        end
    end

    // State registers; reset clears the array so loads return zero immediately
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
            load_count_q   <= {CNT_W{1'b0}};
            store_count_q  <= {CNT_W{1'b0}};
            fault_sticky_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            load_count_q   <= load_count_d;
            store_count_q  <= store_count_d;
            fault_sticky_q <= fault_sticky_d;
        end
    end

    assign read_data    = read_data_s;
    assign fault        = fault_s;
    assign fault_sticky = fault_sticky_q;
    assign load_count   = load_count_q;
    assign store_count  = store_count_q;
endmodule

// File: tb/tb_d_mem.sv
// Self-checking bench for d_mem: byte-addressed reference model compared every
// cycle, plus directed literal checks and a randomized access mix.
module tb_d_mem;
    logic        clock;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] read_data;
    logic        fault;
    logic        fault_sticky;
    logic [15:0] load_count;
    logic [15:0] store_count;

    int checks = 0;
    int passes = 0;

    logic [7:0]  m_bytes [256];
    logic [15:0] m_loads;
    logic [15:0] m_stores;
    logic        m_sticky;

    d_mem #(.DEPTH(64), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .addr(addr), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write), .size(size),
        .load_unsigned(load_unsigned), .read_data(read_data), .fault(fault),
        .fault_sticky(fault_sticky), .load_count(load_count), .store_count(store_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic m_fault(input logic [31:0] a, input logic [1:0] sz,
                                     input logic rd, input logic wr);
        logic bad;
        bad = (a >= 32'd256) || (sz == 2'd3) ||
              (sz == 2'd1 && (a % 32'd2) != 32'd0) ||
              (sz == 2'd2 && (a % 32'd4) != 32'd0);
        return (rd || wr) && bad;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic uns);
        logic [31:0] v;
        int n;
        v = 32'd0;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int k = n - 1; k >= 0; k--) begin
            v = (v << 8) | {24'd0, m_bytes[a[7:0] + 8'(k)]};
        end
        if (!uns && n == 1 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
        if (!uns && n == 2 && v >= 32'd32768) v = v + 32'hFFFF_0000;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model state update
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) m_bytes[i] <= 8'd0;
            m_loads  <= 16'd0;
            m_stores <= 16'd0;
            m_sticky <= 1'b0;
        end else begin
            if (m_fault(addr, size, mem_read, mem_write)) m_sticky <= 1'b1;
            else begin
                if (mem_read)  m_loads  <= m_loads + 16'd1;
                if (mem_write) begin
                    m_stores <= m_stores + 16'd1;
                    for (int k = 0; k < 4; k++) begin
                        if (k < ((size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4))
                            m_bytes[addr[7:0] + 8'(k)] <= write_data[8*k +: 8];
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        logic f;
        f = m_fault(addr, size, mem_read, mem_write);
        chk("fault", {31'd0, fault}, {31'd0, f});
        chk("read_data", read_data, (mem_read && !f) ? m_load(addr, size, load_unsigned) : 32'd0);
        chk("load_count", {16'd0, load_count}, {16'd0, m_loads});
        chk("store_count", {16'd0, store_count}, {16'd0, m_stores});
        chk("fault_sticky", {31'd0, fault_sticky}, {31'd0, m_sticky});
    end

    task automatic op(input logic [31:0] a, input logic [31:0] d, input logic rd,
                      input logic wr, input logic [1:0] sz, input logic uns);
        @(posedge clock);
        #1;
        addr = a; write_data = d; mem_read = rd; mem_write = wr;
        size = sz; load_unsigned = uns;
    endtask

    task automatic mid;
        @(negedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] d;
        reset = 1'b0; addr = 32'd0; write_data = 32'd0; mem_read = 1'b0;
        mem_write = 1'b0; size = 2'd0; load_unsigned = 1'b0;
        mid;
        chk("rst_load_count", {16'd0, load_count}, 32'd0);
        chk("rst_store_count", {16'd0, store_count}, 32'd0);
        chk("rst_sticky", {31'd0, fault_sticky}, 32'd0);
        chk("rst_read_data", read_data, 32'd0);
        #1 reset = 1'b1;

        op(32'h8, 32'hDEADBEEF, 1'b0, 1'b1, 2'd2, 1'b0);
        op(32'h8, 32'd0, 1'b1, 1'b0, 2'd2, 1'b0);
        mid;
        chk("t1_lw", read_data, 32'hDEADBEEF);
        chk("t1_store_count", {16'd0, store_count}, 32'd1);
        chk("t1_fault", {31'd0, fault}, 32'd0);
        op(32'h9, 32'd0, 1'b1, 1'b0, 2'd0, 1'b0); mid;
        chk("t1_load_count", {16'd0, load_count}, 32'd1);
        chk("t2_lb", read_data, 32'hFFFFFFBE);
        op(32'h9, 32'd0, 1'b1, 1'b0, 2'd0, 1'b1); mid; chk("t2_lbu", read_data, 32'h000000BE);
        op(32'hA, 32'd0, 1'b1, 1'b0, 2'd1, 1'b0); mid; chk("t2_lh", read_data, 32'hFFFFDEAD);
        op(32'hA, 32'd0, 1'b1, 1'b0, 2'd1, 1'b1); mid; chk("t2_lhu", read_data, 32'h0000DEAD);

        op(32'hB, 32'h11, 1'b0, 1'b1, 2'd0, 1'b0);
        op(32'h8, 32'd0, 1'b1, 1'b0, 2'd2, 1'b0); mid; chk("t3_sb", read_data, 32'h11ADBEEF);
        op(32'h8, 32'h2233, 1'b0, 1'b1, 2'd1, 1'b0);
        op(32'h8, 32'd0, 1'b1, 1'b0, 2'd2, 1'b0); mid; chk("t3_sh", read_data, 32'h11AD2233);

        op(32'h6, 32'hFFFFFFFF, 1'b0, 1'b1, 2'd2, 1'b0); mid;
        chk("t4_sw_fault", {31'd0, fault}, 32'd1);
        chk("t4_sticky_before", {31'd0, fault_sticky}, 32'd0);
        op(32'h4, 32'd0, 1'b1, 1'b0, 2'd2, 1'b0); mid;
        chk("t4_sticky_after", {31'd0, fault_sticky}, 32'd1);
        chk("t4_store_count", {16'd0, store_count}, 32'd3);
        chk("t4_array_unchanged", read_data, 32'd0);
        op(32'h100, 32'd0, 1'b1, 1'b0, 2'd2, 1'b0); mid;
        chk("t4_range_rd", read_data, 32'd0);
        chk("t4_range_fault", {31'd0, fault}, 32'd1);
        op(32'h0, 32'd0, 1'b1, 1'b0, 2'd3, 1'b0); mid;
        chk("t4_size11_fault", {31'd0, fault}, 32'd1);

        op(32'h10, 32'h12345678, 1'b1, 1'b1, 2'd2, 1'b0); mid;
        chk("t5_rw_old", read_data, 32'd0);
        op(32'h10, 32'd0, 1'b1, 1'b0, 2'd2, 1'b0); mid;
        chk("t5_rw_new", read_data, 32'h12345678);
        chk("t5_store_count", {16'd0, store_count}, 32'd4);

        for (int i = 0; i < 2000; i++) begin
            r = $urandom;
            a = $urandom;
            d = $urandom;
            if (r[3:0] != 4'd0) a = {24'd0, a[7:0]};
            if (r[4]) a = {a[31:2], 2'b00};
            op(a, d, r[5], r[6], r[8:7], r[9]);
        end

        op(32'h14, 32'hCAFEF00D, 1'b0, 1'b1, 2'd2, 1'b0);
        @(negedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        mem_write = 1'b0;
        #3 reset = 1'b1;
        op(32'h14, 32'd0, 1'b1, 1'b0, 2'd2, 1'b0); mid;
        chk("t6_lw_after_rst", read_data, 32'd0);
        chk("t6_load_count", {16'd0, load_count}, 32'd0);
        chk("t6_store_count", {16'd0, store_count}, 32'd0);
        chk("t6_sticky", {31'd0, fault_sticky}, 32'd0);
        for (int i = 0; i < 65536; i++) begin
            a = $urandom;
            d = $urandom;
            op({24'd0, a[7:2], 2'b00}, d, 1'b0, 1'b1, 2'd2, 1'b0);
        end
        op(32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0); mid;
        chk("t6_store_wrap", {16'd0, store_count}, 32'd0);
        chk("t6_load_hold", {16'd0, load_count}, 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
